// File: rtl/id_run_stats.sv
// id_run_stats: collects statistics on the digit-tail "match runs" reported by the
// identifier recognizer, and keeps the characters of the last completed run for readback.
module id_run_stats #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned BUF_DEPTH = 8,
    localparam int unsigned IDX_W    = $clog2(BUF_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    input  logic             match,
    input  logic             flush,
    input  logic             clear,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_char,
    output logic [CNT_W-1:0] run_cnt,
    output logic [LEN_W-1:0] last_len,
    output logic [LEN_W-1:0] max_len,
    output logic             run_done
);

    localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(BUF_DEPTH);
    localparam logic [IDX_W:0]   FILL_MAX = (IDX_W + 1)'(BUF_DEPTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                    state;
    logic [7:0]                char_d;
    logic [LEN_W-1:0]          cur_len;
    logic [BUF_DEPTH-1:0][7:0] cur_buf;
    logic [BUF_DEPTH-1:0][7:0] last_buf;
    logic [IDX_W:0]            last_fill;

    logic [LEN_W-1:0]          base_len;
    logic [LEN_W-1:0]          ext_len;
    logic [LEN_W-1:0]          close_len;
    logic [BUF_DEPTH-1:0][7:0] ext_buf;
    logic [BUF_DEPTH-1:0][7:0] close_buf;
    logic                      close_now;

    // Run as it would look with char_d appended, and the run as it stands if closed now
    always_comb begin
        base_len  = (state == RUN) ? cur_len : '0;
        ext_len   = (base_len == '1) ? base_len : base_len + LEN_W'(1);
        ext_buf   = cur_buf;
        if (base_len < DEPTH_L) begin
            ext_buf[base_len[IDX_W-1:0]] = char_d;
        end
        close_len = match ? ext_len : cur_len;
        close_buf = match ? ext_buf : cur_buf;
        close_now = !clear && (((state == RUN) && !match) || (match && flush));
    end

    // Run tracking FSM with registered statistics; clear beats close beats extend
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            char_d    <= '0;
            cur_len   <= '0;
            cur_buf   <= '0;
            last_buf  <= '0;
            last_fill <= '0;
            run_cnt   <= '0;
            last_len  <= '0;
            max_len   <= '0;
            run_done  <= 1'b0;
        end else begin
            char_d   <= char;
            run_done <= 1'b0;
            if (clear) begin
                state     <= IDLE;
                cur_len   <= '0;
                cur_buf   <= '0;
                last_buf  <= '0;
                last_fill <= '0;
                run_cnt   <= '0;
                last_len  <= '0;
                max_len   <= '0;
            end else if (close_now) begin
                state    <= IDLE;
                cur_len  <= '0;
                run_done <= 1'b1;
                if (run_cnt != '1) begin
                    run_cnt <= run_cnt + CNT_W'(1);
                end
                last_len <= close_len;
                if (close_len > max_len) begin
                    max_len <= close_len;
                end
                last_buf  <= close_buf;
                last_fill <= (close_len >= DEPTH_L) ? FILL_MAX : close_len[IDX_W:0];
            end else if (match) begin
                state   <= RUN;
                cur_len <= ext_len;
                cur_buf <= ext_buf;
            end
        end
    end

    // Readback of the last completed run; entries past the captured length read as zero
    always_comb begin
        rd_char = 8'h00;
        if ({1'b0, rd_idx} < last_fill) begin
            rd_char = last_buf[rd_idx];
        end
    end

endmodule

// File: tb/tb_id_run_stats.sv
// tb_id_run_stats: directed and randomized checks of id_run_stats against a queue-based model.
`timescale 1ns/1ps
module tb_id_run_stats;

    logic        clk;
    logic        reset;
    logic [7:0]  char;
    logic        match;
    logic        flush;
    logic        clear;
    logic [2:0]  rd_idx;

    logic [7:0]  rd_char;
    logic [15:0] run_cnt;
    logic [7:0]  last_len;
    logic [7:0]  max_len;
    logic        run_done;

    logic [7:0]  s_rd_char;
    logic [3:0]  s_run_cnt;
    logic [7:0]  s_last_len;
    logic [7:0]  s_max_len;
    logic        s_run_done;

    int checks = 0;
    int errors = 0;

    id_run_stats u_dut (
        .clk(clk), .reset(reset), .char(char), .match(match), .flush(flush),
        .clear(clear), .rd_idx(rd_idx), .rd_char(rd_char), .run_cnt(run_cnt),
        .last_len(last_len), .max_len(max_len), .run_done(run_done)
    );

    id_run_stats #(.CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .char(char), .match(match), .flush(flush),
        .clear(clear), .rd_idx(rd_idx), .rd_char(s_rd_char), .run_cnt(s_run_cnt),
        .last_len(s_last_len), .max_len(s_max_len), .run_done(s_run_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // ---------------- behavioural model: runs as queues of characters ----------------
    int         m_cnt, m_len, m_last, m_max;
    bit         m_open, m_done, was_open;
    logic [7:0] m_cd;
    logic [7:0] m_cur[$];
    logic [7:0] m_lastbuf[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt = 0; m_len = 0; m_last = 0; m_max = 0;
            m_open = 0; m_done = 0; m_cd = 8'h00;
            m_cur.delete(); m_lastbuf.delete();
        end else begin
            m_done = 0;
            if (clear) begin
                m_cnt = 0; m_len = 0; m_last = 0; m_max = 0; m_open = 0;
                m_cur.delete(); m_lastbuf.delete();
            end else begin
                was_open = m_open;
                if (match) begin
                    m_open = 1;
                    m_len++;
                    if (m_cur.size() < 8) m_cur.push_back(m_cd);
                end
                if ((was_open && !match) || (m_open && flush)) begin
                    m_cnt++;
                    m_last = sat(m_len, 255);
                    if (m_last > m_max) m_max = m_last;
                    m_lastbuf = m_cur;
                    m_cur.delete();
                    m_len = 0;
                    m_open = 0;
                    m_done = 1;
                end
            end
            m_cd = char;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (!reset) begin
            logic [7:0] exp_rd;
            exp_rd = (int'(rd_idx) < m_lastbuf.size()) ? m_lastbuf[rd_idx] : 8'h00;
            chk("run_cnt", 32'(run_cnt), 32'(sat(m_cnt, 65535)));
            chk("run_cnt_w4", 32'(s_run_cnt), 32'(sat(m_cnt, 15)));
            chk("last_len", 32'(last_len), 32'(m_last));
            chk("max_len", 32'(max_len), 32'(m_max));
            chk("run_done", 32'(run_done), 32'(m_done));
            chk("rd_char", 32'(rd_char), 32'(exp_rd));
            chk("last_len_w4", 32'(s_last_len), 32'(m_last));
            chk("max_len_w4", 32'(s_max_len), 32'(m_max));
            chk("run_done_w4", 32'(s_run_done), 32'(m_done));
            chk("rd_char_w4", 32'(s_rd_char), 32'(exp_rd));
        end
    end

    // ---------------- stimulus: recognizer model drives match one cycle late ----------------
    int rec;
    bit pend;

    task automatic step(input logic [7:0] c, input bit f = 1'b0, input bit cl = 1'b0);
        char   = c;
        flush  = f;
        clear  = cl;
        match  = pend;
        rd_idx = 3'($urandom);
        if (c >= 8'h61 && c <= 8'h7a)                 rec = 1;
        else if (c >= 8'h30 && c <= 8'h39 && rec != 0) rec = 2;
        else                                           rec = 0;
        pend = (rec == 2);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) step(s[i]);
    endtask

    task automatic rd_chk(input int idx, input logic [7:0] exp);
        rd_idx = 3'(idx);
        #1;
        chk($sformatf("rd_char[%0d]", idx), 32'(rd_char), 32'(exp));
        step(8'h20);
    endtask

    initial begin
        string alpha;
        logic [7:0] c;
        reset = 1'b1; char = 8'h00; match = 1'b0; flush = 1'b0; clear = 1'b0; rd_idx = '0;
        rec = 0; pend = 1'b0;
        #1;
        chk("reset run_cnt", 32'(run_cnt), 32'd0);
        chk("reset max_len", 32'(max_len), 32'd0);
        chk("reset rd_char", 32'(rd_char), 32'd0);
        chk("reset run_done", 32'(run_done), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // "ab12;" then idle
        send("ab12;");
        step(8'h20);
        chk("t1 run_done", 32'(run_done), 32'd1);
        chk("t1 run_cnt", 32'(run_cnt), 32'd1);
        chk("t1 last_len", 32'(last_len), 32'd2);
        chk("t1 max_len", 32'(max_len), 32'd2);
        chk("t1 model cnt", 32'(m_cnt), 32'd1);
        rd_chk(0, 8'h31);
        rd_chk(1, 8'h32);
        rd_chk(2, 8'h00);

        // "x1 y234 z5 "
        step(8'h20, 1'b0, 1'b1);
        send("x1 y234 z5 ");
        step(8'h20);
        chk("t2 run_cnt", 32'(run_cnt), 32'd3);
        chk("t2 last_len", 32'(last_len), 32'd1);
        chk("t2 max_len", 32'(max_len), 32'd3);
        rd_chk(0, 8'h35);

        // 10 digits closed by flush on the last digit's match cycle
        step(8'h20, 1'b0, 1'b1);
        send("q0123456789");
        step(8'h20, 1'b1, 1'b0);
        chk("t3 run_done", 32'(run_done), 32'd1);
        chk("t3 last_len", 32'(last_len), 32'd10);
        for (int i = 0; i < 8; i++) rd_chk(i, 8'(8'h30 + i));

        // clear during an open run
        step(8'h20, 1'b0, 1'b1);
        send("a12");
        step(8'h20, 1'b0, 1'b1);
        chk("t4 run_done", 32'(run_done), 32'd0);
        chk("t4 run_cnt", 32'(run_cnt), 32'd0);
        chk("t4 last_len", 32'(last_len), 32'd0);
        chk("t4 max_len", 32'(max_len), 32'd0);
        send("b3;");
        step(8'h20);
        chk("t4b run_cnt", 32'(run_cnt), 32'd1);
        chk("t4b last_len", 32'(last_len), 32'd1);

        // asynchronous reset mid-run
        send("c9;");
        #2 reset = 1'b1;
        #1;
        chk("t5 async run_cnt", 32'(run_cnt), 32'd0);
        chk("t5 async last_len", 32'(last_len), 32'd0);
        chk("t5 async rd_char", 32'(rd_char), 32'd0);
        rec = 0; pend = 1'b0; match = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        send("c9;");
        step(8'h20);
        chk("t5 run_cnt", 32'(run_cnt), 32'd1);

        // counter and length saturation
        step(8'h20, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) send("a1 ");
        step(8'h20);
        chk("t6 run_cnt_w4", 32'(s_run_cnt), 32'hF);
        chk("t6 run_cnt", 32'(run_cnt), 32'd18);
        step(8'h61);
        for (int i = 0; i < 300; i++) step(8'h37);
        step(8'h20);
        step(8'h20);
        chk("t6 last_len", 32'(last_len), 32'hFF);
        chk("t6 max_len", 32'(max_len), 32'hFF);

        // randomized stream
        alpha = "abxyz0123456789 ;";
        for (int n = 0; n < 3000; n++) begin
            c = alpha[$urandom_range(0, alpha.len() - 1)];
            step(c, ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0));
        end
        step(8'h20);
        step(8'h20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
